// File: rtl/oven_countdown_timer.sv
// Oven countdown timer core: user-set MM:SS in BCD counted down once per tick, with
// start/pause/clear, door interlock and a timed done/beep phase. All outputs registered.
`timescale 1ns/1ps
module oven_countdown_timer #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_HZ    = 1,
    parameter int BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       clear_i,
    input  logic       inc_min_i,
    input  logic       inc_sec_i,
    input  logic       door_open_i,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       beep
);
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(BEEP_TICKS + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;
    localparam bcd_time_t TIME_MAX = 16'h9959;

    state_t          state;
    bcd_time_t       t;
    bcd_time_t       t_dec;
    bcd_time_t       t_inc_min;
    bcd_time_t       t_inc_sec;
    logic [CW-1:0]   tick_cnt;
    logic [BW-1:0]   beep_cnt;
    logic            tick;

    assign tick     = ((state == RUN) || (state == DONE)) && (tick_cnt == TICK_LAST);
    assign min_tens = t.mt;
    assign min_ones = t.mo;
    assign sec_tens = t.st;
    assign sec_ones = t.so;

    // NOTE: every next-value starts as a copy of the current time so no path leaves it unassigned (no latch).
    always_comb begin
        t_dec = t;
        if (t.so != 4'd0) begin
            t_dec.so = t.so - 4'd1;
        end else begin
            t_dec.so = 4'd9;
            if (t.st != 4'd0) begin
                t_dec.st = t.st - 4'd1;
            end else begin
                t_dec.st = 4'd5;
                if (t.mo != 4'd0) begin
                    t_dec.mo = t.mo - 4'd1;
                end else begin
                    t_dec.mo = 4'd9;
                    t_dec.mt = t.mt - 4'd1;
                end
            end
        end

        t_inc_min = t;
        if (t.mt == 4'd9 && t.mo == 4'd9) begin
            t_inc_min = TIME_MAX;
        end else if (t.mo == 4'd9) begin
            t_inc_min.mo = 4'd0;
            t_inc_min.mt = t.mt + 4'd1;
        end else begin
            t_inc_min.mo = t.mo + 4'd1;
        end

        // A carry out of sec_tens reuses the minute increment; at 99 minutes it saturates instead.
        t_inc_sec = t;
        if (t.st != 4'd5) begin
            t_inc_sec.st = t.st + 4'd1;
        end else if (t.mt == 4'd9 && t.mo == 4'd9) begin
            t_inc_sec = TIME_MAX;
        end else begin
            t_inc_sec.st = 4'd0;
            t_inc_sec.mo = t_inc_min.mo;
            t_inc_sec.mt = t_inc_min.mt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; later assignments in this block override the defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            t        <= '0;
            tick_cnt <= '0;
            beep_cnt <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            beep     <= 1'b0;
        end else begin
            if (state == RUN || state == DONE)
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            if (clear_i) begin
                state    <= IDLE;
                t        <= '0;
                tick_cnt <= '0;
                running  <= 1'b0;
                done     <= 1'b0;
                beep     <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (door_open_i || pause_i) begin
                            state   <= PAUSED;
                            running <= 1'b0;
                        end else if (tick) begin
                            t <= t_dec;
                            if (t_dec == '0) begin
                                state    <= DONE;
                                running  <= 1'b0;
                                done     <= 1'b1;
                                beep     <= 1'b1;
                                tick_cnt <= '0;
                                beep_cnt <= '0;
                            end
                        end
                    end
                    IDLE, PAUSED: begin
                        if (start_i) begin
                            if (t != '0 && !door_open_i) begin
                                state    <= RUN;
                                running  <= 1'b1;
                                tick_cnt <= '0;
                            end
                        end else if (inc_min_i) begin
                            t <= t_inc_min;
                        end else if (inc_sec_i) begin
                            t <= t_inc_sec;
                        end
                    end
                    DONE: begin
                        if (tick) begin
                            if (beep_cnt == BEEP_LAST) begin
                                state <= IDLE;
                                done  <= 1'b0;
                                beep  <= 1'b0;
                            end else begin
                                beep_cnt <= beep_cnt + 1'b1;
                                beep     <= ~beep;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_oven_countdown_timer.sv
// Self-checking bench for oven_countdown_timer: directed scenarios with fixed expectations,
// then random commands compared cycle by cycle against a seconds-based reference model.
`timescale 1ns/1ps
module tb_oven_countdown_timer;
    localparam int CLK_FREQ   = 10;
    localparam int TICK_HZ    = 1;
    localparam int BEEP_TICKS = 3;
    localparam int DIV        = CLK_FREQ / TICK_HZ;
    localparam int MAX_SECS   = 99 * 60 + 59;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0, pause_i = 1'b0, clear_i = 1'b0;
    logic       inc_min_i = 1'b0, inc_sec_i = 1'b0, door_open_i = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done, beep;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining time kept as plain seconds.
    int m_mode, m_secs, m_phase, m_beeps;
    bit m_beep;

    always #5 clk = ~clk;

    oven_countdown_timer #(
        .CLK_FREQ  (CLK_FREQ),
        .TICK_HZ   (TICK_HZ),
        .BEEP_TICKS(BEEP_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .pause_i    (pause_i),
        .clear_i    (clear_i),
        .inc_min_i  (inc_min_i),
        .inc_sec_i  (inc_sec_i),
        .door_open_i(door_open_i),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .done       (done),
        .beep       (beep)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd_of(input int s);
        int m, sec;
        m   = s / 60;
        sec = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    function automatic logic [15:0] shown();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({shown(), running, done, beep});
    endfunction

    function automatic logic [31:0] model_vec();
        return 32'({bcd_of(m_secs), m_mode == M_RUN, m_mode == M_DONE, m_beep});
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_secs  = 0;
        m_phase = 0;
        m_beeps = 0;
        m_beep  = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit im, input bit is,
                              input bit door);
        bit tk;
        tk = (m_mode == M_RUN || m_mode == M_DONE) && (m_phase == DIV - 1);
        if (m_mode == M_RUN || m_mode == M_DONE) m_phase = tk ? 0 : m_phase + 1;
        if (c) begin
            m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_beep = 1'b0;
        end else if (m_mode == M_RUN) begin
            if (door || p) begin
                m_mode = M_PAUSED;
            end else if (tk) begin
                m_secs--;
                if (m_secs == 0) begin
                    m_mode = M_DONE; m_phase = 0; m_beeps = 0; m_beep = 1'b1;
                end
            end
        end else if (m_mode == M_IDLE || m_mode == M_PAUSED) begin
            if (s) begin
                if (m_secs > 0 && !door) begin
                    m_mode = M_RUN; m_phase = 0;
                end
            end else if (im) begin
                m_secs = (m_secs + 60 > MAX_SECS) ? MAX_SECS : m_secs + 60;
            end else if (is) begin
                m_secs = (m_secs + 10 > MAX_SECS) ? MAX_SECS : m_secs + 10;
            end
        end else if (tk) begin
            m_beeps++;
            if (m_beeps == BEEP_TICKS) begin
                m_mode = M_IDLE; m_beep = 1'b0;
            end else begin
                m_beep = ~m_beep;
            end
        end
    endtask

    // One clock edge with the given pulses; outputs are sampled 1 ns after the edge.
    task automatic step(input bit s, input bit p, input bit c, input bit im, input bit is);
        start_i = s; pause_i = p; clear_i = c; inc_min_i = im; inc_sec_i = is;
        model_step(s, p, c, im, is, door_open_i);
        @(posedge clk);
        #1;
        start_i = 1'b0; pause_i = 1'b0; clear_i = 1'b0; inc_min_i = 1'b0; inc_sec_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #23 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_outputs", dut_vec(), 32'h0);

        // Set and borrow: 01:10 minus 11 ticks.
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        check("set_0110", 32'(shown()), 32'h0110);
        step(1, 0, 0, 0, 0);
        check("start_running", 32'(running), 32'h1);
        idle(110);
        check("borrow_0059", 32'(shown()), 32'h0059);
        check("borrow_running", 32'(running), 32'h1);
        step(0, 0, 1, 0, 0);
        check("clear_after_borrow", dut_vec(), 32'h0);

        // Completion from 00:10 and the beep phase.
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        idle(99);
        check("done_not_early", 32'(done), 32'h0);
        idle(1);
        check("done_rise", 32'({shown(), running, done, beep}), 32'h00000003);
        idle(9);
        check("beep_tick1", 32'(beep), 32'h1);
        idle(1);
        check("beep_tick2", 32'(beep), 32'h0);
        idle(10);
        check("beep_tick3", 32'(beep), 32'h1);
        idle(9);
        check("done_held", 32'(done), 32'h1);
        idle(1);
        check("done_to_idle", dut_vec(), 32'h0);

        // Door interlock from 00:30.
        repeat (3) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        idle(25);
        check("door_pre_0028", 32'(shown()), 32'h0028);
        door_open_i = 1'b1;
        step(0, 0, 0, 0, 0);
        check("door_pauses", 32'(running), 32'h0);
        idle(49);
        check("door_frozen", 32'(shown()), 32'h0028);
        step(1, 0, 0, 0, 0);
        check("door_start_ignored", 32'(running), 32'h0);
        door_open_i = 1'b0;
        step(1, 0, 0, 0, 0);
        check("door_resume", 32'(running), 32'h1);
        idle(9);
        check("resume_no_early_dec", 32'(shown()), 32'h0028);
        idle(1);
        check("resume_dec_at_div", 32'(shown()), 32'h0027);
        step(0, 0, 1, 0, 0);

        // Zero start and saturation.
        step(1, 0, 0, 0, 0);
        check("zero_start_ignored", 32'(running), 32'h0);
        repeat (99) step(0, 0, 0, 1, 0);
        check("inc_min_99", 32'(shown()), 32'h9900);
        step(0, 0, 0, 1, 0);
        check("sat_min", 32'(shown()), 32'h9959);
        repeat (6) step(0, 0, 0, 0, 1);
        check("sat_sec", 32'(shown()), 32'h9959);
        step(0, 0, 1, 0, 0);

        // Priority: clear beats start in PAUSED; inc_min beats inc_sec.
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("paused", 32'({shown(), running}), 32'({16'h0010, 1'b0}));
        step(1, 0, 1, 0, 0);
        check("clear_over_start", dut_vec(), 32'h0);
        step(0, 0, 0, 1, 1);
        check("min_over_sec", 32'(shown()), 32'h0100);
        step(0, 0, 1, 0, 0);

        // Random commands against the reference model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (door_open_i) begin
                if ($urandom_range(0, 49) == 0) door_open_i = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                door_open_i = 1'b1;
            end
            step(r < 20, r >= 20 && r < 30, r >= 30 && r < 33, r == 33, r >= 40 && r < 67);
            check("rand", dut_vec(), model_vec());
        end
        door_open_i = 1'b0;
        step(0, 0, 1, 0, 0);

        // Asynchronous reset mid-RUN at 05:00.
        repeat (5) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        idle(3);
        check("pre_reset_run", 32'({shown(), running}), 32'({16'h0500, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_now", dut_vec(), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0);
        check("post_reset_idle", dut_vec(), 32'h0);
        step(0, 0, 0, 0, 1);
        check("post_reset_inc", 32'(shown()), 32'h0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
